// File: rtl/powlib_rrflop.sv
// Round-robin shared output register: grants one of N requesters per cycle and
// loads its data into a single valid/ready register; full throughput when drained.
module powlib_rrflop #(
  parameter int             W    = 8,
  parameter int             N    = 4,
  parameter logic [W-1:0]   INIT = '0,
  parameter int             SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   din,
  output logic [N-1:0]     gnt,
  output logic [W-1:0]     q,
  output logic             qvld,
  output logic [SW-1:0]    qsel,
  input  logic             rdy
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] win;
  logic [W-1:0]  win_dat;
  logic          found;
  logic          free;
  logic          take;

  assign free = !qvld || rdy;
  assign take = free && found && !rst;

  // Scan from ptr upward with wrap; the first requester seen wins.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    win_dat = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win     = SW'(idx);
        win_dat = din[idx*W +: W];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (take) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= INIT;
      qvld <= 1'b0;
      qsel <= '0;
      ptr  <= '0;
    end else if (take) begin
      q    <= win_dat;
      qsel <= win;
      qvld <= 1'b1;
      ptr  <= (win == SW'(N-1)) ? '0 : win + 1'b1;
    end else if (qvld && rdy) begin
      qvld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_powlib_rrflop.sv
// Directed self-checking bench for powlib_rrflop (W=8, N=4, INIT=0).
module tb_powlib_rrflop;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        qvld;
  logic [1:0]  qsel;
  logic        rdy;

  int checks;
  int errors;
  int consumed_11;
  int base_11;

  powlib_rrflop #(.W(8), .N(4), .INIT(8'h00)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .din  (din),
    .gnt  (gnt),
    .q    (q),
    .qvld (qvld),
    .qsel (qsel),
    .rdy  (rdy)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  // Count handshakes that consume the value 8'h11.
  always @(posedge clk) begin
    if (!rst && qvld && rdy && q == 8'h11) consumed_11 <= consumed_11 + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    consumed_11 = 0;
    clk_en      = 1'b0;
    rst         = 1'b1;
    req         = 4'b1111;
    din         = 32'h0;
    rdy         = 1'b1;
    #1;
    chk("rst_q",    {24'h0, q},    32'h00);
    chk("rst_qvld", {31'h0, qvld}, 32'h0);
    chk("rst_qsel", {30'h0, qsel}, 32'h0);
    chk("rst_gnt",  {28'h0, gnt},  32'h0);

    req = 4'b0000;
    #2;
    rst    = 1'b0;
    clk_en = 1'b1;
    step();
    step();
    chk("idle_qvld", {31'h0, qvld}, 32'h0);
    chk("idle_q",    {24'h0, q},    32'h00);
    chk("idle_gnt",  {28'h0, gnt},  32'h0);

    // Single requester 2.
    din = {8'h13, 8'hA5, 8'h11, 8'h10};
    req = 4'b0100;
    #1;
    chk("single_gnt", {28'h0, gnt}, 32'h4);
    step();
    chk("single_q",    {24'h0, q},    32'hA5);
    chk("single_qsel", {30'h0, qsel}, 32'h2);
    chk("single_qvld", {31'h0, qvld}, 32'h1);
    req = 4'b0000;
    step();
    chk("drain_qvld", {31'h0, qvld}, 32'h0);
    chk("drain_q",    {24'h0, q},    32'hA5);
    chk("drain_qsel", {30'h0, qsel}, 32'h2);

    // Wrap and skip from ptr=3.
    din = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b0011;
    #1;
    chk("wrap_gnt0", {28'h0, gnt}, 32'h1);
    step();
    chk("wrap_q0", {24'h0, q}, 32'h10);
    #1;
    chk("wrap_gnt1", {28'h0, gnt}, 32'h2);
    step();
    chk("wrap_qsel1", {30'h0, qsel}, 32'h1);
    chk("wrap_q1",    {24'h0, q},    32'h11);

    // Full contention from ptr=2: order 2,3,0,1 back to back.
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (2 + k) % 4;
      #1;
      chk($sformatf("full_gnt%0d", k), {28'h0, gnt}, 32'(1 << idx));
      step();
      chk($sformatf("full_qsel%0d", k), {30'h0, qsel}, 32'(idx));
      chk($sformatf("full_q%0d", k),    {24'h0, q},    32'(8'h10 + idx));
      chk($sformatf("full_qvld%0d", k), {31'h0, qvld}, 32'h1);
    end

    // Backpressure holding 8'h11 for 3 cycles.
    rdy     = 1'b0;
    base_11 = consumed_11;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_gnt%0d", k), {28'h0, gnt}, 32'h0);
      step();
      chk($sformatf("bp_q%0d", k),    {24'h0, q},    32'h11);
      chk($sformatf("bp_qsel%0d", k), {30'h0, qsel}, 32'h1);
      chk($sformatf("bp_qvld%0d", k), {31'h0, qvld}, 32'h1);
    end
    rdy = 1'b1;
    #1;
    chk("bp_release_gnt", {28'h0, gnt}, 32'h4);
    step();
    chk("bp_release_q",    {24'h0, q},    32'h12);
    chk("bp_release_qsel", {30'h0, qsel}, 32'h2);
    step();
    chk("bp_consumed_once", 32'(consumed_11 - base_11), 32'h1);
    chk("after_bp_q", {24'h0, q}, 32'h13);

    // Grants 0 and 1 leave ptr=2 with qvld=1, then reset mid-cycle.
    step();
    step();
    chk("pre_rst_qsel", {30'h0, qsel}, 32'h1);
    chk("pre_rst_qvld", {31'h0, qvld}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_qvld", {31'h0, qvld}, 32'h0);
    chk("midrst_q",    {24'h0, q},    32'h00);
    chk("midrst_qsel", {30'h0, qsel}, 32'h0);
    chk("midrst_gnt",  {28'h0, gnt},  32'h0);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_gnt", {28'h0, gnt}, 32'h1);
    step();
    chk("post_rst_qsel", {30'h0, qsel}, 32'h0);
    chk("post_rst_q",    {24'h0, q},    32'h10);
    chk("post_rst_qvld", {31'h0, qvld}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/powlib_rrflop.md
Name: powlib_rrflop

Overview:
- Round-robin arbiter that shares a single W-bit output register among N requesters.
- Each cycle it grants at most one requester and loads that requester's data into the register. The register presents the data downstream with a valid/ready handshake.
- Sits between several producer stages and one consumer, in place of a bare valid-gated flipflop, wherever one register is a shared resource.

Parameters:
- W, 8, data width per requester and of the output register.
- N, 4, number of requesters (N >= 2).
- INIT, 0, W-bit reset value of q.
- SW, clog2(N) (derived, minimum 1), width of the grant index and round-robin pointer.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N  per-requester request; req[i] asserts that din slice i holds valid data.
- din  input  N*W  requester data; slice i is din[i*W +: W].
- gnt  output  N  one-hot grant, combinational from req, ptr, qvld and rdy. Requester i's transfer completes in a cycle with req[i] && gnt[i].
- q  output  W  registered data.
- qvld  output  1  q holds untaken data.
- qsel  output  SW  index of the requester whose data is in q.
- rdy  input  1  downstream accepts q this cycle when qvld && rdy.

Behaviour:
- Reset (rst=1, asynchronous, no clk edge needed):
  - q=INIT, qvld=0, qsel=0, ptr=0.
  - gnt=0 while rst is high.
- Register free condition: free = !qvld || rdy. A slot is free if it is empty, or if it is being drained in the same cycle.
- Grant selection, when free=1 and req!=0:
  - Winner is the first i with req[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - gnt[winner]=1; all other gnt bits are 0.
- Grant suppression: when free=0 or req=0, gnt=0.
  - Requests are held externally. The block does not latch req.
- Clock edge with a grant to winner w:
  - q <= din slice w, qsel <= w, qvld <= 1.
  - ptr <= (w+1) mod N; wrap from N-1 goes to 0.
- Clock edge, no grant, qvld && rdy: qvld <= 0; q and qsel hold their values.
- Clock edge, no grant, otherwise: all state holds.
- Simultaneous drain and load (qvld=1, rdy=1, req!=0):
  - Old q is consumed and the new winner is loaded on the same edge.
  - qvld stays 1, giving full throughput of one transfer per cycle.
- Latency: data granted in cycle t appears on q/qvld after edge t, i.e. in cycle t+1.
- Fairness:
  - A requester holding req continuously is granted within N grants.
  - With all N requesting, the grant order is strictly cyclic.
- ptr advances only on a grant. It is unaffected by drain-only cycles and stalls.
- Backpressure (qvld=1, rdy=0): q, qsel, qvld and ptr all hold; gnt=0.
- Non-power-of-two N: ptr and qsel never take values >= N.
- Reset mid-operation: pending q data is discarded and ptr returns to 0. Grants resume on the first edge after rst deasserts.

Test Plan:
- Reset check: assert rst with no clock running -> q=INIT, qvld=0, qsel=0, gnt=0 immediately. After release, req=0 -> outputs stay at reset values.
- Single requester: N=4, W=8, req=4'b0100, din slice2=8'hA5, rdy=1 -> gnt=4'b0100 in the same cycle; next cycle q=8'hA5, qsel=2, qvld=1. The next grant scan starts at ptr=3.
- Full contention: req=4'b1111 held, rdy=1, din slices = 8'h10,8'h11,8'h12,8'h13 -> qsel sequence 0,1,2,3,0,... with matching q values; qvld stays 1 every cycle (back-to-back throughput).
- Backpressure: qvld=1 holding 8'h11, rdy=0 for 3 cycles with req=4'b1111 -> gnt=0, and q/qsel/ptr are unchanged for those 3 cycles. On rdy=1, grant goes to the index after qsel, q is updated on the next edge, and the old value is counted as consumed exactly once.
- Wrap and skip: ptr=3, req=4'b0011 -> gnt=4'b0001, then ptr=1. Next cycle with the same req -> gnt=4'b0010.
- Reset mid-stream: pulse rst while qvld=1 and ptr=2 -> qvld drops to 0 asynchronously. After release with req=4'b1111, the first grant is index 0.
